// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous data memory between the CPU and a DMA/debug port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU always wins ties.
module mem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_in,
  input  logic          cpu_we_in,
  input  logic [AW-1:0] cpu_addr_in,
  input  logic [DW-1:0] cpu_wdata_in,
  output logic          cpu_ack_out,
  output logic [DW-1:0] cpu_rdata_out,
  input  logic          dma_req_in,
  input  logic          dma_we_in,
  input  logic [AW-1:0] dma_addr_in,
  input  logic [DW-1:0] dma_wdata_in,
  input  logic          dma_lock_in,
  output logic          dma_ack_out,
  output logic [DW-1:0] dma_rdata_out,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  localparam int unsigned CW      = $clog2(LOCK_MAX + 1);
  localparam logic        OWN_CPU = 1'b0;
  localparam logic        OWN_DMA = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RSP = 2'd2} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic          acc_we;
  logic [CW-1:0] lock_cnt;

  logic lock_ovr;
  logic grant_dma;
  logic in_acc;
  logic in_rsp;

  // DMA keeps the bus while it asked for a lock, held the previous grant and has budget left.
  assign lock_ovr = dma_lock_in && (last == OWN_DMA) && (lock_cnt < CW'(LOCK_MAX));

  always_comb begin
    grant_dma = 1'b0;
    if (dma_req_in && !cpu_req_in) begin
      grant_dma = 1'b1;
    end else if (dma_req_in && cpu_req_in) begin
      if (lock_ovr) begin
        grant_dma = 1'b1;
      end
`ifdef MEM_ARB_RR_EN
      else begin
        grant_dma = (last == OWN_CPU);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_CPU;
      last     <= OWN_DMA;
      acc_we   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_in || dma_req_in) begin
            owner  <= grant_dma;
            last   <= grant_dma;
            acc_we <= grant_dma ? dma_we_in : cpu_we_in;
            state  <= ACC;
            // Only locked DMA grants taken over a waiting CPU consume the lock budget.
            if (grant_dma && cpu_req_in && dma_lock_in) begin
              if (lock_cnt < CW'(LOCK_MAX)) begin
                lock_cnt <= lock_cnt + CW'(1);
              end
            end else begin
              lock_cnt <= '0;
            end
          end
        end
        ACC:     state <= RSP;
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state directly so that reset blanks them in the same cycle.
  assign in_acc = !rst && (state == ACC);
  assign in_rsp = !rst && (state == RSP);

  assign mem_en_out    = in_acc;
  assign mem_we_out    = in_acc && ((owner == OWN_DMA) ? dma_we_in : cpu_we_in);
  assign mem_addr_out  = in_acc ? ((owner == OWN_DMA) ? dma_addr_in : cpu_addr_in) : '0;
  assign mem_wdata_out = in_acc ? ((owner == OWN_DMA) ? dma_wdata_in : cpu_wdata_in) : '0;

  assign cpu_ack_out   = in_rsp && (owner == OWN_CPU);
  assign dma_ack_out   = in_rsp && (owner == OWN_DMA);
  assign cpu_rdata_out = (cpu_ack_out && !acc_we) ? mem_rdata_in : '0;
  assign dma_rdata_out = (dma_ack_out && !acc_we) ? mem_rdata_in : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the processor's single synchronous data memory between the CPU load/store path and a DMA/debug requester. It sits between the CPU datapath memory interface and the memory macro. Each access runs a fixed three-state sequence with a req/ack handshake. An optional DMA lock grants short bursts, bounded by a starvation counter.

## Interface
Parameters:
- AW, 8, address width
- DW, 16, data width
- LOCK_MAX, 4, max consecutive locked DMA grants while CPU is waiting (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_in  in  1  CPU access request, held until ack
- cpu_we_in  in  1  CPU write enable (1 = write)
- cpu_addr_in  in  AW  CPU address
- cpu_wdata_in  in  DW  CPU write data
- cpu_ack_out  out  1  CPU access complete, one-cycle pulse
- cpu_rdata_out  out  DW  CPU read data, valid with cpu_ack_out
- dma_req_in, dma_we_in, dma_addr_in, dma_wdata_in  in  1/1/AW/DW  DMA equivalents
- dma_lock_in  in  1  DMA requests priority for its next grant
- dma_ack_out, dma_rdata_out  out  1/DW  DMA equivalents
- mem_en_out  out  1  memory access strobe
- mem_we_out  out  1  memory write enable
- mem_addr_out  out  AW  memory address
- mem_wdata_out  out  DW  memory write data
- mem_rdata_in  in  DW  memory read data, valid one cycle after mem_en_out

## Operation
- States: IDLE, ACC, RSP. Registers: state, owner (CPU/DMA), last (last granted owner), lock_cnt (0..LOCK_MAX).
- IDLE: if no request, stay in IDLE. Otherwise grant as follows:
  - Only one requester: grant it.
  - Both requesting, lock override active: grant DMA. Lock override means dma_lock_in=1, last=DMA and lock_cnt<LOCK_MAX.
  - Otherwise the tie is broken by policy (see Configuration).
  - On a grant: owner←winner, last←winner, go to ACC.
- lock_cnt:
  - +1 on each DMA grant made with cpu_req_in=1 and dma_lock_in=1.
  - Clears to 0 on any CPU grant, and on any DMA grant where cpu_req_in=0 or dma_lock_in=0.
- ACC: mem_en_out=1. mem_we_out/addr/wdata are muxed from the owner's inputs. Go to RSP unconditionally.
- RSP: owner's ack_out=1. Owner's rdata_out=mem_rdata_in for reads, 0 for writes. Go to IDLE.
- Non-owner ack is 0, and non-owner rdata_out is 0.
- Outside ACC: mem_en_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0.
- Requester rules:
  - Inputs stay stable from req assertion through the ack cycle.
  - req high in the cycle after ack is a new request.
  - A req dropped before ack is a protocol violation; the block completes the access anyway.

## Timing
- Latency: req sampled high at edge N (in IDLE) → mem_en_out high in cycle N..N+1 → ack in cycle N+1..N+2. That is 2 cycles from req to ack.
- Throughput: one access per 3 cycles, including IDLE.
- Reset:
  - Any cycle with rst=1 forces all outputs to 0 combinationally.
  - At the next edge: state=IDLE, owner=CPU, last=DMA, lock_cnt=0.
- Reset in ACC or RSP aborts the access: no ack is issued, and a write already strobed in ACC is not undone. The requester must re-request after reset.
- Simultaneous req with rst=1: ignored. Arbitration starts at the first edge with rst=0.
- lock_cnt saturates at LOCK_MAX. At saturation a pending CPU request always wins the next arbitration.

## Configuration
- MEM_ARB_RR_EN defined: both requesting without lock override → grant goes to the requester ≠ last (round robin). The first tie after reset goes to CPU.
- MEM_ARB_RR_EN undefined: fixed priority, CPU always wins ties. last is still tracked for the lock logic.

## Test plan
- Single CPU read: cpu_req_in=1, we=0, addr=0x12, memory holds 0xBEEF. Expect mem_en_out=1 with addr 0x12 one cycle later, then cpu_ack_out=1 and cpu_rdata_out=0xBEEF the next cycle. dma_ack_out stays 0.
- DMA write: dma_req_in=1, we=1, addr=0x40, wdata=0x1234. Expect an ACC cycle with mem_we_out=1, addr 0x40, wdata 0x1234, then dma_ack_out=1 and dma_rdata_out=0.
- Continuous contention, both req held high, no lock:
  - RR build: grants alternate CPU, DMA, CPU, DMA, with one ack every 3 cycles.
  - Fixed build: CPU is granted every time and DMA never.
- Lock burst, both req high, dma_lock_in=1, LOCK_MAX=4 (RR build):
  - Grant order is CPU first (tie after reset), then DMA, DMA, DMA, DMA (lock_cnt reaches 4), then CPU.
  - lock_cnt clears on the CPU grant.
- Reset mid-access: assert rst during ACC of a CPU read. Expect all outputs 0 that cycle and no ack. Then release rst with cpu_req_in=1; the access completes 2 cycles after release.
- Idle bus: no requests for 10 cycles. Expect mem_en_out=0, both acks 0 and all mem_* outputs 0 throughout.
